// File: rtl/rec_pkg.sv
// Shared transport types: system-state encoding, speed codes, speed helper functions.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rec_pkg;

    // Encodings are consumed directly by SRAM, I2S and DSP blocks; bit 2 marks record-side states.
    typedef enum logic [2:0] {
        ST_P_STOP  = 3'b000,
        ST_P_PLAY  = 3'b010,
        ST_P_PAUSE = 3'b011,
        ST_R_STOP  = 3'b100,
        ST_INIT    = 3'b101,
        ST_R_REC   = 3'b110,
        ST_R_PAUSE = 3'b111
    } state_t;

    // Speed code: 0000 = x1, 1xxx = x(xxx+1) fast, 0xxx = x1/(xxx+1) slow.
    localparam logic [3:0] SPD_X1   = 4'b0000;
    localparam logic [3:0] SPD_X2   = 4'b1001;
    localparam logic [3:0] SPD_X8   = 4'b1111;
    localparam logic [3:0] SPD_DIV2 = 4'b0001;
    localparam logic [3:0] SPD_DIV8 = 4'b0111;

    // Pointer advance per fetch.
    function automatic logic [3:0] speed_step(input logic [3:0] code);
        return code[3] ? ({1'b0, code[2:0]} + 4'd1) : 4'd1;
    endfunction

    // Number of play requests per fetch.
    function automatic logic [3:0] slow_div(input logic [3:0] code);
        return (!code[3] && (code[2:0] != 3'd0)) ? ({1'b0, code[2:0]} + 4'd1) : 4'd1;
    endfunction

    // One step toward x8, saturating.
    function automatic logic [3:0] speed_faster(input logic [3:0] code);
        if (code == SPD_X1)
            return SPD_X2;
        else if (code[3])
            return (code == SPD_X8) ? SPD_X8 : code + 4'd1;
        else
            return code - 4'd1;
    endfunction

    // One step toward x1/8, saturating.
    function automatic logic [3:0] speed_slower(input logic [3:0] code);
        if (code == SPD_X1)
            return SPD_DIV2;
        else if (code[3])
            return (code == SPD_X2) ? SPD_X1 : code - 4'd1;
        else
            return (code == SPD_DIV8) ? SPD_DIV8 : code + 4'd1;
    endfunction

endpackage

// File: rtl/play_pointer.sv
// Play read pointer: speed-scaled advance, slow-rate request divider, fetch pulse, end-of-recording detect.
// Latency: fetch pulse and address appear one cycle after the accepted request; o_end is combinational.
// Backpressure: none; every request in the enabled state is consumed the cycle it arrives.
// Ports: i_en = in P_PLAY, i_clear = stop key, i_req = DSP sample request, i_speed = speed code,
//        i_rec_len = recording length, o_fetch/o_fetch_addr = SRAM read, o_end = last fetch of recording.
module play_pointer
    import rec_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_clear,
    input  logic              i_req,
    input  logic [3:0]        i_speed,
    input  logic [ADDR_W:0]   i_rec_len,
    output logic              o_fetch,
    output logic [ADDR_W-1:0] o_fetch_addr,
    output logic              o_end
);

    logic [ADDR_W-1:0] ptr;
    logic [2:0]        div_cnt;
    logic [3:0]        step;
    logic [3:0]        div;
    logic [ADDR_W:0]   sum;
    logic              take;

    always_comb begin
        step = speed_step(i_speed);
        div  = slow_div(i_speed);
        // One extra bit so the sum never wraps past the end of the address space.
        sum  = {1'b0, ptr} + {{(ADDR_W-3){1'b0}}, step};
        // >= rather than == so a speed change mid-count cannot strand the divider.
        take = i_en && i_req && !i_clear && (({1'b0, div_cnt} + 4'd1) >= div);
        o_end = take && (sum >= i_rec_len);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr          <= '0;
            div_cnt      <= '0;
            o_fetch      <= 1'b0;
            o_fetch_addr <= '0;
        end else begin
            o_fetch <= take;
            if (i_clear) begin
                ptr     <= '0;
                div_cnt <= '0;
            end else if (i_en && i_req) begin
                if (take) begin
                    o_fetch_addr <= ptr;
                    div_cnt      <= '0;
                    ptr          <= o_end ? '0 : sum[ADDR_W-1:0];
                end else begin
                    div_cnt <= div_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/transport_ctrl.sv
// Transport sequencer: system state FSM, play-speed register, record address and recording length.
// Latency: all outputs registered; a key pulse at edge n is reflected after edge n.
// Backpressure: none; key pulses and sample strobes are consumed the cycle they arrive.
// Ports: keys i_play_record/i_stop/i_fast/i_slow, level i_mode/i_init_done, strobes i_rec_valid/i_play_req;
//        o_state system state, o_speed speed code, o_rec_addr/o_rec_len record side, o_fetch/o_fetch_addr play side.
module transport_ctrl
    import rec_pkg::*;
#(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] ADDR_MAX = '1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init_done,
    input  logic              i_play_record,
    input  logic              i_stop,
    input  logic              i_mode,
    input  logic              i_fast,
    input  logic              i_slow,
    input  logic              i_rec_valid,
    input  logic              i_play_req,
    output logic [2:0]        o_state,
    output logic [3:0]        o_speed,
    output logic [ADDR_W-1:0] o_rec_addr,
    output logic [ADDR_W:0]   o_rec_len,
    output logic              o_fetch,
    output logic [ADDR_W-1:0] o_fetch_addr
);

    localparam logic [ADDR_W:0] FULL_LEN = {1'b0, ADDR_MAX} + (ADDR_W+1)'(1);

    state_t state;
    logic   stop_key;
    logic   rec_wr;
    logic   rec_full;
    logic   play_end;

    assign o_state  = state;
    assign stop_key = i_stop && (state != ST_INIT);
    assign rec_wr   = (state == ST_R_REC) && i_rec_valid;
    assign rec_full = rec_wr && (o_rec_addr == ADDR_MAX);

    play_pointer #(.ADDR_W(ADDR_W)) u_play_pointer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (state == ST_P_PLAY),
        .i_clear      (stop_key),
        .i_req        (i_play_req),
        .i_speed      (o_speed),
        .i_rec_len    (o_rec_len),
        .o_fetch      (o_fetch),
        .o_fetch_addr (o_fetch_addr),
        .o_end        (play_end)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_INIT;
            o_speed    <= SPD_X1;
            o_rec_addr <= '0;
            o_rec_len  <= '0;
        end else begin
            // Record-side states (and INIT) always run at x1.
            if (state[2])
                o_speed <= SPD_X1;
            else if (i_fast && !i_slow)
                o_speed <= speed_faster(o_speed);
            else if (i_slow && !i_fast)
                o_speed <= speed_slower(o_speed);

            if (state == ST_INIT) begin
                if (i_init_done)
                    state <= i_mode ? ST_R_STOP : ST_P_STOP;
            end else if (i_stop) begin
                state <= state[2] ? ST_R_STOP : ST_P_STOP;
                if ((state == ST_R_REC) || (state == ST_R_PAUSE)) begin
                    o_rec_len  <= {1'b0, o_rec_addr};
                    o_rec_addr <= '0;
                end
            end else if (rec_full) begin
                o_rec_len  <= FULL_LEN;
                o_rec_addr <= '0;
                state      <= ST_R_STOP;
            end else if (play_end) begin
                state <= ST_P_STOP;
            end else begin
                if (rec_wr)
                    o_rec_addr <= o_rec_addr + ADDR_W'(1);
                // A play key that has no effect (empty recording) lets a mode change through.
                if (i_play_record && (state == ST_R_STOP)) begin
                    state      <= ST_R_REC;
                    o_rec_addr <= '0;
                end else if (i_play_record && (state == ST_P_STOP) && (o_rec_len != '0))
                    state <= ST_P_PLAY;
                else if (i_play_record && (state == ST_R_REC))
                    state <= ST_R_PAUSE;
                else if (i_play_record && (state == ST_R_PAUSE))
                    state <= ST_R_REC;
                else if (i_play_record && (state == ST_P_PLAY))
                    state <= ST_P_PAUSE;
                else if (i_play_record && (state == ST_P_PAUSE))
                    state <= ST_P_PLAY;
                else if ((state == ST_P_STOP) && i_mode)
                    state <= ST_R_STOP;
                else if ((state == ST_R_STOP) && !i_mode)
                    state <= ST_P_STOP;
            end
        end
    end

endmodule

// File: tb/tb_transport_ctrl.sv
// Bench for transport_ctrl: directed key sequences, a behavioural model checked every cycle,
// and literal expectations at key points of each scenario.
module tb_transport_ctrl;

    localparam int AW   = 20;
    localparam int AMAX = 7;

    localparam logic [2:0] S_INIT = 3'b101, S_PSTOP = 3'b000, S_PLAY = 3'b010, S_PPAUSE = 3'b011;
    localparam logic [2:0] S_RSTOP = 3'b100, S_REC = 3'b110, S_RPAUSE = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, init_done, play_record, stop, mode, fast, slow, rec_valid, play_req;
    logic [2:0]    state;
    logic [3:0]    speed;
    logic [AW-1:0] rec_addr, fetch_addr;
    logic [AW:0]   rec_len;
    logic          fetch;

    transport_ctrl #(.ADDR_W(AW), .ADDR_MAX(20'd7)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_init_done   (init_done),
        .i_play_record (play_record),
        .i_stop        (stop),
        .i_mode        (mode),
        .i_fast        (fast),
        .i_slow        (slow),
        .i_rec_valid   (rec_valid),
        .i_play_req    (play_req),
        .o_state       (state),
        .o_speed       (speed),
        .o_rec_addr    (rec_addr),
        .o_rec_len     (rec_len),
        .o_fetch       (fetch),
        .o_fetch_addr  (fetch_addr)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;
    int fq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Speed held as a signed rank: -7 (x1/8) .. 0 (x1) .. +7 (x8).
    logic [2:0] m_state;
    int m_rank, m_addr, m_len, m_ptr, m_reqs, m_faddr;
    bit m_fetch;
    logic [2:0] n_state;
    int n_rank, n_addr, n_len, n_ptr, n_reqs, n_faddr, step, need;
    bit n_fetch, busy;

    function automatic int code_of(input int r);
        if (r == 0) return 0;
        if (r > 0)  return 8 + r;
        return -r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = S_INIT; m_rank = 0; m_addr = 0; m_len = 0;
            m_ptr = 0; m_reqs = 0; m_fetch = 0; m_faddr = 0;
        end else begin
            n_state = m_state; n_rank = m_rank; n_addr = m_addr; n_len = m_len;
            n_ptr = m_ptr; n_reqs = m_reqs; n_faddr = m_faddr; n_fetch = 0; busy = 0;

            if (m_state[2]) n_rank = 0;
            else if (fast && !slow) n_rank = (m_rank < 7) ? m_rank + 1 : 7;
            else if (slow && !fast) n_rank = (m_rank > -7) ? m_rank - 1 : -7;

            if (m_state == S_INIT) begin
                if (init_done) n_state = mode ? S_RSTOP : S_PSTOP;
            end else if (stop) begin
                n_state = m_state[2] ? S_RSTOP : S_PSTOP;
                n_ptr = 0; n_reqs = 0;
                if (m_state == S_REC || m_state == S_RPAUSE) begin
                    n_len = m_addr; n_addr = 0;
                end
            end else begin
                if (m_state == S_REC && rec_valid) begin
                    if (m_addr == AMAX) begin
                        n_len = AMAX + 1; n_addr = 0; n_state = S_RSTOP; busy = 1;
                    end else n_addr = m_addr + 1;
                end
                if (m_state == S_PLAY && play_req) begin
                    step = (m_rank > 0) ? m_rank + 1 : 1;
                    need = (m_rank < 0) ? 1 - m_rank : 1;
                    if (m_reqs + 1 >= need) begin
                        n_fetch = 1; n_faddr = m_ptr; n_reqs = 0;
                        if (m_ptr + step >= m_len) begin
                            n_ptr = 0; n_state = S_PSTOP; busy = 1;
                        end else n_ptr = m_ptr + step;
                    end else n_reqs = m_reqs + 1;
                end
                if (!busy) begin
                    if (play_record && m_state == S_RSTOP) begin n_state = S_REC; n_addr = 0; end
                    else if (play_record && m_state == S_PSTOP && m_len != 0) n_state = S_PLAY;
                    else if (play_record && m_state == S_REC)    n_state = S_RPAUSE;
                    else if (play_record && m_state == S_RPAUSE) n_state = S_REC;
                    else if (play_record && m_state == S_PLAY)   n_state = S_PPAUSE;
                    else if (play_record && m_state == S_PPAUSE) n_state = S_PLAY;
                    else if (m_state == S_PSTOP && mode)  n_state = S_RSTOP;
                    else if (m_state == S_RSTOP && !mode) n_state = S_PSTOP;
                end
            end
            m_state = n_state; m_rank = n_rank; m_addr = n_addr; m_len = n_len;
            m_ptr = n_ptr; m_reqs = n_reqs; m_fetch = n_fetch; m_faddr = n_faddr;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_state",      32'(state),      32'(m_state));
            chk("m_speed",      32'(speed),      32'(code_of(m_rank)));
            chk("m_rec_addr",   32'(rec_addr),   32'(m_addr));
            chk("m_rec_len",    32'(rec_len),    32'(m_len));
            chk("m_fetch",      32'(fetch),      32'(m_fetch));
            chk("m_fetch_addr", 32'(fetch_addr), 32'(m_faddr));
            if (fetch === 1'b1) fq.push_back(int'(fetch_addr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit pr, input bit st, input bit fa, input bit sl, input bit rv, input bit rq);
        play_record = pr; stop = st; fast = fa; slow = sl; rec_valid = rv; play_req = rq;
        @(posedge clk); #1;
        play_record = 0; stop = 0; fast = 0; slow = 0; rec_valid = 0; play_req = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; init_done = 0; mode = 1;
        play_record = 0; stop = 0; fast = 0; slow = 0; rec_valid = 0; play_req = 0;
        @(posedge clk); #1;
        cmp_on = 1'b1;
        idle();

        // 1. reset values, then INIT -> R_STOP
        chk("rst_state", 32'(state), 32'(S_INIT));
        chk("rst_speed", 32'(speed), 32'h0);
        chk("rst_rec_addr", 32'(rec_addr), 32'h0);
        chk("rst_rec_len", 32'(rec_len), 32'h0);
        chk("rst_fetch", 32'(fetch), 32'h0);
        rst_n = 1;
        idle();
        chk("init_hold", 32'(state), 32'(S_INIT));
        init_done = 1;
        idle();
        chk("init_to_rstop", 32'(state), 32'(S_RSTOP));

        // 2. record five samples then stop
        cyc(1, 0, 0, 0, 0, 0);
        chk("rec_start", 32'(state), 32'(S_REC));
        for (int i = 0; i < 5; i++) begin
            chk("rec_addr_seq", 32'(rec_addr), 32'(i));
            cyc(0, 0, 0, 0, 1, 0);
        end
        cyc(0, 1, 0, 0, 0, 0);
        chk("rec_stop_state", 32'(state), 32'(S_RSTOP));
        chk("rec_stop_addr", 32'(rec_addr), 32'h0);
        chk("rec_len_5", 32'(rec_len), 32'd5);

        // 3. play x1 to the end, then x2
        mode = 0;
        idle();
        chk("mode_to_pstop", 32'(state), 32'(S_PSTOP));
        fq.delete();
        cyc(1, 0, 0, 0, 0, 0);
        chk("play_start", 32'(state), 32'(S_PLAY));
        repeat (5) cyc(0, 0, 0, 0, 0, 1);
        idle();
        chk("x1_end_state", 32'(state), 32'(S_PSTOP));
        chk("x1_fetch_cnt", 32'(fq.size()), 32'd5);
        for (int i = 0; i < fq.size() && i < 5; i++) chk("x1_fetch_addr", 32'(fq[i]), 32'(i));

        cyc(0, 0, 1, 0, 0, 0);
        chk("x2_code", 32'(speed), 32'b1001);
        fq.delete();
        cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        idle();
        chk("x2_end_state", 32'(state), 32'(S_PSTOP));
        chk("x2_fetch_cnt", 32'(fq.size()), 32'd3);
        for (int i = 0; i < fq.size() && i < 3; i++) chk("x2_fetch_addr", 32'(fq[i]), 32'(2 * i));
        cyc(0, 1, 0, 0, 0, 0);
        chk("x2_stop", 32'(state), 32'(S_PSTOP));

        // 4. speed saturation both ways, record mode forces x1
        cyc(0, 0, 0, 1, 0, 0);
        chk("back_to_x1", 32'(speed), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 1, 0, 0, 0);
            chk("fast_seq", 32'(speed), (i < 8) ? 32'(8 + i) : 32'hF);
        end
        repeat (7) cyc(0, 0, 0, 1, 0, 0);
        chk("slow_back_x1", 32'(speed), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            chk("slow_seq", 32'(speed), (i < 8) ? 32'(i) : 32'h7);
        end
        mode = 1;
        idle();
        idle();
        chk("rec_mode_state", 32'(state), 32'(S_RSTOP));
        chk("rec_mode_speed", 32'(speed), 32'h0);
        mode = 0;
        idle();
        chk("back_pstop", 32'(state), 32'(S_PSTOP));

        // 5. x1/2 play and simultaneous fast+slow
        cyc(0, 0, 0, 1, 0, 0);
        chk("div2_code", 32'(speed), 32'b0001);
        fq.delete();
        cyc(1, 0, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0, 1);
        idle();
        chk("div2_fetch_cnt", 32'(fq.size()), 32'd2);
        for (int i = 0; i < fq.size() && i < 2; i++) chk("div2_fetch_addr", 32'(fq[i]), 32'(i));
        chk("div2_still_play", 32'(state), 32'(S_PLAY));
        cyc(0, 0, 1, 1, 0, 0);
        chk("fast_slow_same", 32'(speed), 32'b0001);
        cyc(0, 1, 0, 0, 0, 0);
        chk("div2_stop", 32'(state), 32'(S_PSTOP));

        // 6. stop beats play key, full recording, pause, reset mid-record
        cyc(1, 1, 0, 0, 0, 0);
        chk("stop_beats_play", 32'(state), 32'(S_PSTOP));
        mode = 1;
        idle();
        cyc(1, 0, 0, 0, 0, 0);
        repeat (8) cyc(0, 0, 0, 0, 1, 0);
        chk("full_state", 32'(state), 32'(S_RSTOP));
        chk("full_len", 32'(rec_len), 32'd8);
        chk("full_addr", 32'(rec_addr), 32'h0);
        cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 1, 0);
        chk("rec3_addr", 32'(rec_addr), 32'd3);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rec_pause", 32'(state), 32'(S_RPAUSE));
        cyc(0, 0, 0, 0, 1, 0);
        chk("pause_ignores_valid", 32'(rec_addr), 32'd3);
        rst_n = 0;
        #1;
        chk("midrst_state", 32'(state), 32'(S_INIT));
        chk("midrst_len", 32'(rec_len), 32'h0);
        chk("midrst_addr", 32'(rec_addr), 32'h0);
        chk("midrst_speed", 32'(speed), 32'h0);
        idle();
        rst_n = 1;
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
